mem_coalescer: RTL and testbench
================================

Name: mem_coalescer

Overview:
- Sequential memory-access coalescer for the SIMD load/store path. Sits between the lane address-generation stage and the memory-segment request port.
- Accepts one warp-wide request: per-lane addresses plus an active mask. It then emits one memory transaction per distinct aligned segment touched by the active lanes, in lowest-lane-first order.
- Each transaction carries the segment base and the lanes it serves. The block is generalised in lane count, address width and segment size, and adds handshaking, iteration and completion reporting.

Parameters:
- N_LANES, 32, number of SIMD lanes (≥2, power of two).
- N_LANES_LOG, 5, log2(N_LANES).
- ADDR_W, 32, byte-address width per lane.
- SEG_BYTES_LOG, 6, log2 of segment size in bytes (64 B segments); must be < ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  warp request valid
- req_ready  out  1  block idle, can accept a request
- req_addr  in  N_LANES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W]
- req_mask  in  N_LANES  active lanes
- txn_valid  out  1  transaction valid
- txn_ready  in  1  memory accepts transaction
- txn_seg  out  ADDR_W-SEG_BYTES_LOG  segment number, i.e. addr[ADDR_W-1:SEG_BYTES_LOG]
- txn_lanes  out  N_LANES  lanes served by this transaction
- txn_leader  out  N_LANES_LOG  lowest lane index in txn_lanes
- txn_last  out  1  this is the final transaction of the request
- done  out  1  one-cycle pulse: request fully issued
- txn_count  out  N_LANES_LOG+1  number of transactions issued for the last request; valid when done=1

Behaviour:
- Reset (rst=1 at a clk edge): FSM→IDLE; pending mask, address registers and txn counter cleared. Outputs after reset: req_ready=1, txn_valid=0, done=0, txn_count=0, txn_* data=0. Reset mid-request abandons all remaining transactions; no done pulse is generated.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr into an address bank and req_mask into pending; clear the counter.
  - Next state is ISSUE if req_mask≠0, else FIN.
- ISSUE:
  - req_ready=0, txn_valid=1.
  - leader = lowest set bit of pending.
  - txn_seg = segment of addr[leader].
  - txn_lanes[i] = pending[i] & (seg(addr[i]) == txn_seg).
  - txn_last = (pending & ~txn_lanes) == 0.
- Stability: all txn_* outputs are combinational from registered pending/address state. They must not change while txn_valid=1 and txn_ready=0.
- Accept (txn_valid & txn_ready):
  - pending ← pending & ~txn_lanes; counter +1.
  - If txn_last, next state is FIN; otherwise stay in ISSUE. The next transaction is presented the following cycle with no bubble.
- FIN: done=1 for exactly one cycle; txn_count = counter (held until the next request is accepted); next state IDLE.
- Throughput: one transaction per cycle under continuous txn_ready. Request-to-first-txn latency is 1 cycle. Total occupancy is K+2 cycles for K segments.
- Zero mask: no transaction; done pulses 1 cycle after acceptance with txn_count=0.
- Each active lane appears in exactly one transaction. Inactive lanes never appear, even when they share a segment.
- Segment comparison uses full upper bits; there is no wrap or aliasing. Addresses at the top of the space (all ones) are handled normally.
- req_valid while busy is ignored; req_ready=0 in ISSUE and FIN.

Decomposition:
- Shared defines header: SEG_BYTES_LOG, lane count/log, address width, state encodings.
- One sub-module, first_one_enc: parametrised lowest-set-bit priority encoder (N_LANES→N_LANES_LOG index + any flag).
- Segment compare and lane-mask generation stay inline in mem_coalescer.

Test Plan:
- All 32 lanes active, addr[i]=0x1000+4i (128 B span), txn_ready=1 → 2 txns:
  - seg 0x40, lanes 0x0000FFFF, leader 0;
  - seg 0x41, lanes 0xFFFF0000, leader 16, last=1;
  - done with txn_count=2.
- mask=0x80000001, addr0=addr31=0x2000 → 1 txn, lanes 0x80000001, leader 0, last=1; count=1.
- Fully scattered: addr[i]=i<<6, mask=all ones → 32 txns, lanes=1<<k in order, last only on the 32nd; count=32; 34 cycles total.
- txn_ready held low 5 cycles mid-request → txn_seg, txn_lanes, txn_leader and txn_last are stable throughout; no lane is lost or duplicated.
- req_mask=0 → no txn_valid; done on the cycle after acceptance; txn_count=0; req_ready back to 1 after FIN.
- rst asserted during the 2nd of 3 transactions → next cycle txn_valid=0, req_ready=1, no done; a new request is then processed correctly.

Source files
------------

// File: rtl/mem_coalescer_pkg.sv
// Shared definitions for the memory-access coalescer: default geometry and FSM state encoding.
package mem_coalescer_pkg;

  localparam int N_LANES_DEF       = 32;
  localparam int N_LANES_LOG_DEF   = 5;
  localparam int ADDR_W_DEF        = 32;
  localparam int SEG_BYTES_LOG_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_coalescer_first_one_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit plus an any-set flag.
module first_one_enc #(
  parameter int N     = 32,
  parameter int N_LOG = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic [N_LOG-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = N_LOG'(i);
    end
  end

endmodule

// File: rtl/mem_coalescer.sv
// Warp-wide memory coalescer: issues one transaction per distinct aligned segment
// touched by the active lanes, lowest lane first.
module mem_coalescer
  import mem_coalescer_pkg::*;
#(
  parameter int N_LANES       = N_LANES_DEF,
  parameter int N_LANES_LOG   = N_LANES_LOG_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int SEG_BYTES_LOG = SEG_BYTES_LOG_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [N_LANES*ADDR_W-1:0]   req_addr,
  input  logic [N_LANES-1:0]          req_mask,
  output logic                        txn_valid,
  input  logic                        txn_ready,
  output logic [ADDR_W-SEG_BYTES_LOG-1:0] txn_seg,
  output logic [N_LANES-1:0]          txn_lanes,
  output logic [N_LANES_LOG-1:0]      txn_leader,
  output logic                        txn_last,
  output logic                        done,
  output logic [N_LANES_LOG:0]        txn_count
);

  localparam int SEG_W = ADDR_W - SEG_BYTES_LOG;

  state_e                        state_q, state_d;
  logic [N_LANES-1:0]            pend_q, pend_d;
  logic [N_LANES-1:0][SEG_W-1:0] seg_q, seg_d;
  logic [N_LANES_LOG:0]          cnt_q, cnt_d;

  logic [N_LANES-1:0][SEG_W-1:0]       req_seg;
  logic [N_LANES*SEG_BYTES_LOG-1:0]    offs_unused;
  logic [N_LANES_LOG-1:0]              lead_idx;
  logic                                lead_any;
  logic [SEG_W-1:0]                    lead_seg;
  logic [N_LANES-1:0]                  match;
  logic                                issuing;
  logic                                is_last;

  // Only the segment number of each lane address matters; byte offsets are dropped at capture.
  for (genvar g = 0; g < N_LANES; g++) begin : g_split
    assign req_seg[g] = req_addr[g*ADDR_W+SEG_BYTES_LOG +: SEG_W];
    assign offs_unused[g*SEG_BYTES_LOG +: SEG_BYTES_LOG] = req_addr[g*ADDR_W +: SEG_BYTES_LOG];
  end

  first_one_enc #(
    .N     (N_LANES),
    .N_LOG (N_LANES_LOG)
  ) u_lead (
    .vec_i (pend_q),
    .idx_o (lead_idx),
    .any_o (lead_any)
  );

  assign lead_seg = seg_q[lead_idx];

  always_comb begin
    match = '0;
    for (int i = 0; i < N_LANES; i++) begin
      match[i] = pend_q[i] && (seg_q[i] == lead_seg);
    end
  end

  assign issuing = (state_q == ST_ISSUE) && lead_any;
  assign is_last = ((pend_q & ~match) == '0);

  assign txn_valid  = issuing;
  assign txn_seg    = issuing ? lead_seg : '0;
  assign txn_lanes  = issuing ? match    : '0;
  assign txn_leader = issuing ? lead_idx : '0;
  assign txn_last   = issuing && is_last;
  assign txn_count  = cnt_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    seg_d     = seg_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pend_d  = req_mask;
          seg_d   = req_seg;
          cnt_d   = '0;
          state_d = (req_mask != '0) ? ST_ISSUE : ST_FIN;
        end
      end
      ST_ISSUE: begin
        if (!lead_any) begin
          state_d = ST_FIN;
        end else if (txn_ready) begin
          pend_d = pend_q & ~match;
          cnt_d  = cnt_q + 1'b1;
          if (is_last) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_coalescer.sv
// Directed bench for mem_coalescer with hand-computed expectations.
module tb_mem_coalescer;

  localparam int N  = 32;
  localparam int NL = 5;
  localparam int W  = 32;
  localparam int SB = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [N*W-1:0]    req_addr;
  logic [N-1:0]      req_mask;
  logic              txn_valid;
  logic              txn_ready;
  logic [W-SB-1:0]   txn_seg;
  logic [N-1:0]      txn_lanes;
  logic [NL-1:0]     txn_leader;
  logic              txn_last;
  logic              done;
  logic [NL:0]       txn_count;

  int n_assert = 0;
  int n_fail   = 0;
  time t0, t1;

  mem_coalescer #(
    .N_LANES(N), .N_LANES_LOG(NL), .ADDR_W(W), .SEG_BYTES_LOG(SB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_mask(req_mask),
    .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_seg(txn_seg), .txn_lanes(txn_lanes),
    .txn_leader(txn_leader), .txn_last(txn_last),
    .done(done), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_txn(input string tag, input logic [W-SB-1:0] seg, input logic [N-1:0] lanes,
                         input logic [NL-1:0] lead, input logic last);
    chk({tag, ".valid"},  64'(txn_valid),  64'(1'b1));
    chk({tag, ".seg"},    64'(txn_seg),    64'(seg));
    chk({tag, ".lanes"},  64'(txn_lanes),  64'(lanes));
    chk({tag, ".leader"}, 64'(txn_leader), 64'(lead));
    chk({tag, ".last"},   64'(txn_last),   64'(last));
  endtask

  task automatic start(input logic [N-1:0] mask);
    req_mask  = mask;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic addr_linear();
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = 32'h1000 + 32'(4 * i);
  endtask

  task automatic addr_three();
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = 32'h3000 + 32'((i / 11) * 64);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_mask = '0; txn_ready = 1'b1;
    tick(); tick();
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.txn_valid", 64'(txn_valid), 64'd0);
    chk("rst.done",      64'(done),      64'd0);
    chk("rst.count",     64'(txn_count), 64'd0);
    chk("rst.seg",       64'(txn_seg),   64'd0);
    chk("rst.lanes",     64'(txn_lanes), 64'd0);
    chk("rst.leader",    64'(txn_leader),64'd0);
    chk("rst.last",      64'(txn_last),  64'd0);
    rst = 1'b0;
    tick();

    // Two segments, all lanes active
    addr_linear();
    start('1);
    chk("lin.req_ready", 64'(req_ready), 64'd0);
    chk_txn("lin.t0", 26'h40, 32'h0000FFFF, 5'd0, 1'b0);
    tick();
    chk_txn("lin.t1", 26'h41, 32'hFFFF0000, 5'd16, 1'b1);
    tick();
    chk("lin.done",  64'(done),      64'd1);
    chk("lin.count", 64'(txn_count), 64'd2);
    chk("lin.fin_valid", 64'(txn_valid), 64'd0);
    tick();
    chk("lin.idle_done",  64'(done),      64'd0);
    chk("lin.idle_ready", 64'(req_ready), 64'd1);
    chk("lin.held_count", 64'(txn_count), 64'd2);

    // Sparse mask; inactive lanes share the segment but must not appear
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = 32'h2000;
    start(32'h80000001);
    chk_txn("sparse.t0", 26'h80, 32'h80000001, 5'd0, 1'b1);
    tick();
    chk("sparse.done",  64'(done),      64'd1);
    chk("sparse.count", 64'(txn_count), 64'd1);
    tick();

    // Fully scattered, one lane per segment, plus occupancy timing
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = 32'(i) << 6;
    t0 = $time;
    start('1);
    for (int k = 0; k < N; k++) begin
      chk_txn($sformatf("scat.t%0d", k), 26'(k), 32'(1) << k, 5'(k), 1'(k == N - 1));
      tick();
    end
    chk("scat.done",  64'(done),      64'd1);
    chk("scat.count", 64'(txn_count), 64'd32);
    tick();
    t1 = $time;
    chk("scat.ready",  64'(req_ready),     64'd1);
    chk("scat.cycles", 64'((t1 - t0) / 10), 64'd34);

    // Backpressure: outputs stable while stalled, then three segments drain
    addr_three();
    txn_ready = 1'b0;
    start('1);
    for (int s = 0; s < 5; s++) begin
      chk_txn($sformatf("stall.c%0d", s), 26'hC0, 32'h000007FF, 5'd0, 1'b0);
      tick();
    end
    chk_txn("stall.t0", 26'hC0, 32'h000007FF, 5'd0, 1'b0);
    txn_ready = 1'b1;
    tick();
    chk_txn("stall.t1", 26'hC1, 32'h003FF800, 5'd11, 1'b0);
    tick();
    chk_txn("stall.t2", 26'hC2, 32'hFFC00000, 5'd22, 1'b1);
    tick();
    chk("stall.done",  64'(done),      64'd1);
    chk("stall.count", 64'(txn_count), 64'd3);
    tick();

    // Zero mask
    start('0);
    chk("zero.valid", 64'(txn_valid), 64'd0);
    chk("zero.done",  64'(done),      64'd1);
    chk("zero.count", 64'(txn_count), 64'd0);
    chk("zero.ready", 64'(req_ready), 64'd0);
    tick();
    chk("zero.idle_ready", 64'(req_ready), 64'd1);
    chk("zero.idle_done",  64'(done),      64'd0);

    // Reset during the second of three transactions
    addr_three();
    start('1);
    chk_txn("rr.t0", 26'hC0, 32'h000007FF, 5'd0, 1'b0);
    tick();
    chk_txn("rr.t1", 26'hC1, 32'h003FF800, 5'd11, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr.valid", 64'(txn_valid), 64'd0);
    chk("rr.ready", 64'(req_ready), 64'd1);
    chk("rr.done",  64'(done),      64'd0);
    chk("rr.count", 64'(txn_count), 64'd0);
    tick();
    chk("rr.done2",  64'(done),      64'd0);
    chk("rr.valid2", 64'(txn_valid), 64'd0);
    addr_linear();
    start('1);
    chk_txn("rr.n0", 26'h40, 32'h0000FFFF, 5'd0, 1'b0);
    tick();
    chk_txn("rr.n1", 26'h41, 32'hFFFF0000, 5'd16, 1'b1);
    tick();
    chk("rr.ndone",  64'(done),      64'd1);
    chk("rr.ncount", 64'(txn_count), 64'd2);
    tick();

    // Top of the address space
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = (i < 2) ? 32'hFFFFFFFF : 32'h0;
    start(32'h00000007);
    chk_txn("top.t0", 26'h3FFFFFF, 32'h00000003, 5'd0, 1'b0);
    tick();
    chk_txn("top.t1", 26'h0, 32'h00000004, 5'd2, 1'b1);
    tick();
    chk("top.count", 64'(txn_count), 64'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
